// File: rtl/sap1_sram_pkg.sv
// Shared types and helpers for the SAP-1 clocked SRAM with program loader.
package sap1_sram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StClear,
    StDone
  } state_e;

  // Zero-extended inputs leave the XOR unchanged, so one width serves all callers.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sap1_sram_array.sv
// Plain storage array: one write port, one registered read port. Contents are not reset.
module sap1_sram_array #(
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned Width     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [Width-1:0]     rdata_o
);

  localparam int unsigned Depth = 2**AddrWidth;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Non-blocking update means a same-cycle read sees the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sap1_sram_loader.sv
// SAP-1 SRAM with CPU run port and a stream-load / sweep-clear sequencer.
// Define SRAM_PARITY_EN to store an even-parity bit per word and flag it on reads.
module sap1_sram_loader
  import sap1_sram_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 4,
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_not_prog,
  input  logic                  ce_bar,
  input  logic                  we_bar,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  prog_start,
  input  logic [ADDR_WIDTH-1:0] prog_base,
  input  logic                  prog_valid,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  prog_last,
  output logic                  prog_ready,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  prog_done,
  output logic [ADDR_WIDTH:0]   prog_count,
  output logic                  parity_err
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
`ifdef SRAM_PARITY_EN
  localparam int unsigned MemWidth = DATA_WIDTH + 1;
`else
  localparam int unsigned MemWidth = DATA_WIDTH;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;

  logic                  cpu_wr, cpu_rd, seq_we, mem_we;
  logic [DATA_WIDTH-1:0] seq_data, wdata_raw;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [MemWidth-1:0]   mem_wdata, mem_rdata;

  assign cpu_wr = run_not_prog & ~ce_bar & ~we_bar;
  assign cpu_rd = run_not_prog & ~ce_bar & we_bar;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    prog_ready = 1'b0;
    busy       = 1'b0;
    prog_done  = 1'b0;
    seq_we     = 1'b0;
    seq_data   = prog_data;
    case (state_q)
      StIdle: begin
        if (!run_not_prog) begin
          if (clear_req) begin
            state_d = StClear;
            ptr_d   = '0;
          end else if (prog_start) begin
            state_d = StLoad;
            ptr_d   = prog_base;
            count_d = '0;
          end
        end
      end
      StLoad: begin
        busy = 1'b1;
        if (run_not_prog) begin
          state_d = StIdle;
        end else begin
          prog_ready = 1'b1;
          if (prog_valid) begin
            seq_we  = 1'b1;
            ptr_d   = ptr_q + ADDR_WIDTH'(1);
            count_d = count_q + (ADDR_WIDTH + 1)'(1);
            // Stop at DEPTH words so a wrapped load never overwrites its own data.
            if (prog_last || count_d == (ADDR_WIDTH + 1)'(DEPTH)) state_d = StDone;
          end
        end
      end
      StClear: begin
        busy = 1'b1;
        if (run_not_prog) begin
          state_d = StIdle;
        end else begin
          seq_we   = 1'b1;
          seq_data = CLEAR_VALUE;
          ptr_d    = ptr_q + ADDR_WIDTH'(1);
          if (&ptr_q) state_d = StDone;
        end
      end
      StDone: begin
        prog_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_we    = run_not_prog ? cpu_wr : seq_we;
  assign mem_waddr = run_not_prog ? addr : ptr_q;
  assign wdata_raw = run_not_prog ? wr_data : seq_data;
  assign rd_valid_d = cpu_rd;

`ifdef SRAM_PARITY_EN
  assign mem_wdata  = {even_parity(64'(wdata_raw)), wdata_raw};
  // Stored word plus parity bit must XOR to zero; only meaningful on the read cycle.
  assign parity_err = rd_valid_q & (^mem_rdata);
`else
  assign mem_wdata  = wdata_raw;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  sap1_sram_array #(
    .AddrWidth(ADDR_WIDTH),
    .Width    (MemWidth)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .re_i   (cpu_rd),
    .raddr_i(addr),
    .rdata_o(mem_rdata)
  );

  assign rd_data    = mem_rdata[DATA_WIDTH-1:0];
  assign rd_valid   = rd_valid_q;
  assign prog_count = count_q;

endmodule

// File: tb/tb_sap1_sram_loader.sv
// Directed self-checking bench for sap1_sram_loader (default 4-bit address, 8-bit data).
module tb_sap1_sram_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_not_prog, ce_bar, we_bar;
  logic [3:0] addr;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid;
  logic       prog_start;
  logic [3:0] prog_base;
  logic       prog_valid;
  logic [7:0] prog_data;
  logic       prog_last, prog_ready, clear_req, busy, prog_done;
  logic [4:0] prog_count;
  logic       parity_err;

  int tests = 0;
  int fails = 0;

  sap1_sram_loader dut (
    .clk         (clk),
    .rst         (rst),
    .run_not_prog(run_not_prog),
    .ce_bar      (ce_bar),
    .we_bar      (we_bar),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .prog_start  (prog_start),
    .prog_base   (prog_base),
    .prog_valid  (prog_valid),
    .prog_data   (prog_data),
    .prog_last   (prog_last),
    .prog_ready  (prog_ready),
    .clear_req   (clear_req),
    .busy        (busy),
    .prog_done   (prog_done),
    .prog_count  (prog_count),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    ce_bar = 1'b0; we_bar = 1'b0; addr = a; wr_data = d;
    tick();
    ce_bar = 1'b1; we_bar = 1'b1;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [7:0] d, output logic v);
    ce_bar = 1'b0; we_bar = 1'b1; addr = a;
    tick();
    d = rd_data;
    v = rd_valid;
    ce_bar = 1'b1;
  endtask

  task automatic start_load(input logic [3:0] base);
    prog_base = base; prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
  endtask

  logic [7:0] d;
  logic       v;
  int         n, dones;

  initial begin
    rst = 1'b1; run_not_prog = 1'b1; ce_bar = 1'b1; we_bar = 1'b1;
    addr = '0; wr_data = '0; prog_start = 1'b0; prog_base = '0;
    prog_valid = 1'b0; prog_data = '0; prog_last = 1'b0; clear_req = 1'b0;
    tick(); tick();
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_prog_ready", prog_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_prog_done", prog_done, 0);
    check_eq("rst_prog_count", prog_count, 0);
    check_eq("rst_parity_err", parity_err, 0);
    rst = 1'b0;
    tick();

    // CPU write then registered read
    cpu_write(4'd3, 8'hA5);
    check_eq("cpu_wr_no_valid", rd_valid, 0);
    cpu_read(4'd3, d, v);
    check_eq("cpu_rd_data", d, 8'hA5);
    check_eq("cpu_rd_valid", v, 1);
    check_eq("cpu_rd_parity", parity_err, 0);
    tick();
    check_eq("idle_rd_valid_low", rd_valid, 0);
    check_eq("idle_rd_data_hold", rd_data, 8'hA5);

    // Load of three words from base 14, wrapping to 0
    run_not_prog = 1'b0;
    tick();
    start_load(4'd14);
    check_eq("load_busy", busy, 1);
    check_eq("load_ready", prog_ready, 1);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      prog_valid = 1'b1;
      prog_data  = 8'h11 * 8'(i + 1);
      prog_last  = (i == 2);
      tick();
      if (prog_done) dones++;
    end
    prog_valid = 1'b0; prog_last = 1'b0;
    check_eq("load3_busy_low", busy, 0);
    tick();
    if (prog_done) dones++;
    check_eq("load3_done_pulses", dones, 1);
    check_eq("load3_count", prog_count, 3);
    run_not_prog = 1'b1;
    cpu_read(4'd14, d, v); check_eq("load3_mem14", d, 8'h11);
    cpu_read(4'd15, d, v); check_eq("load3_mem15", d, 8'h22);
    cpu_read(4'd0, d, v);  check_eq("load3_mem0", d, 8'h33);

    // Full-depth load with gapped valid and no prog_last
    run_not_prog = 1'b0;
    tick();
    start_load(4'd0);
    n = 0; dones = 0;
    for (int c = 0; c < 40; c++) begin
      prog_valid = c[0];
      prog_data  = 8'h40 + 8'(n);
      if (prog_valid && prog_ready) n++;
      tick();
      if (prog_done) dones++;
    end
    check_eq("full_ready_after", prog_ready, 0);
    prog_valid = 1'b0;
    check_eq("full_accepted", n, 16);
    check_eq("full_done_pulses", dones, 1);
    check_eq("full_count", prog_count, 16);
    run_not_prog = 1'b1;
    cpu_read(4'd0, d, v);  check_eq("full_mem0", d, 8'h40);
    cpu_read(4'd15, d, v); check_eq("full_mem15", d, 8'h4F);

    // clear_req beats simultaneous prog_start
    run_not_prog = 1'b0;
    tick();
    clear_req = 1'b1; prog_start = 1'b1; prog_base = 4'd7;
    tick();
    clear_req = 1'b0; prog_start = 1'b0;
    check_eq("clr_ready_low", prog_ready, 0);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    check_eq("clr_busy_cycles", n, 16);
    check_eq("clr_done", prog_done, 1);
    check_eq("clr_count_kept", prog_count, 16);
    tick();
    check_eq("clr_done_one_cycle", prog_done, 0);
    run_not_prog = 1'b1;
    for (int a = 0; a < 16; a++) begin
      cpu_read(4'(a), d, v);
      check_eq($sformatf("clr_mem%0d", a), d, 8'h00);
    end

    // Abort a load after two words by returning to run mode
    run_not_prog = 1'b0;
    tick();
    start_load(4'd4);
    dones = 0;
    prog_valid = 1'b1; prog_data = 8'h77; tick();
    prog_data = 8'h88; tick();
    prog_valid = 1'b0;
    run_not_prog = 1'b1;
    tick();
    if (prog_done) dones++;
    check_eq("abort_busy", busy, 0);
    tick();
    if (prog_done) dones++;
    check_eq("abort_no_done", dones, 0);
    check_eq("abort_count", prog_count, 2);
    cpu_read(4'd4, d, v); check_eq("abort_mem4", d, 8'h77);
    cpu_read(4'd5, d, v); check_eq("abort_mem5", d, 8'h88);
    cpu_read(4'd6, d, v); check_eq("abort_mem6", d, 8'h00);

`ifdef SRAM_PARITY_EN
    cpu_read(4'd5, d, v);
    check_eq("par_clean", parity_err, 0);
    force dut.u_array.mem_q[5][0] = 1'b1;
    cpu_read(4'd5, d, v);
    check_eq("par_err_flag", parity_err, 1);
    check_eq("par_err_data", d, 8'h89);
    release dut.u_array.mem_q[5][0];
    cpu_read(4'd4, d, v);
    check_eq("par_other_clean", parity_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sap1_sram_loader.md
Name: sap1_sram_loader

Overview:
- Clocked, parametrised successor to the SAP-1 combinational/latched SRAM.
- Run mode: serves the CPU bus with active-low ce_bar/we_bar and a registered read.
- Program mode: an internal sequencer bulk-loads words from a valid/ready stream at auto-incrementing addresses, or sweep-clears the array.
- Sits between the CPU bus, the front-panel/UART programmer, and the memory array.

Parameters:
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, word width in bits.
- CLEAR_VALUE, 0, DATA_WIDTH-bit word written by the clear sweep.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- run_not_prog  in  1  1 = run mode (CPU bus), 0 = program mode (sequencer).
- ce_bar  in  1  CPU chip enable, active low; run mode only.
- we_bar  in  1  CPU write enable, active low; run mode only.
- addr  in  ADDR_WIDTH  CPU address.
- wr_data  in  DATA_WIDTH  CPU write data.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  one-cycle pulse: rd_data updated.
- prog_start  in  1  pulse: start load at prog_base.
- prog_base  in  ADDR_WIDTH  load start address, sampled on prog_start.
- prog_valid  in  1  stream word valid.
- prog_data  in  DATA_WIDTH  stream word.
- prog_last  in  1  marks final word, qualified by prog_valid.
- prog_ready  out  1  sequencer accepts a word this cycle.
- clear_req  in  1  pulse: clear the whole array.
- busy  out  1  sequencer is in LOAD or CLEAR.
- prog_done  out  1  one-cycle pulse: load or clear completed normally.
- prog_count  out  ADDR_WIDTH+1  words written by the last or current load.
- parity_err  out  1  see Optional Feature.

Behaviour:
- Reset: rd_data=0, rd_valid=0, prog_ready=0, busy=0, prog_done=0, prog_count=0, parity_err=0, FSM=IDLE. Array contents are not reset.
- Run mode, CPU access when ce_bar=0 at a clk edge:
  - we_bar=0: mem[addr] <= wr_data.
  - we_bar=1: rd_data <= mem[addr] and rd_valid=1 on the next cycle (latency 1).
  - ce_bar=1: rd_data holds; rd_valid=0.
  - A read of an address written in the same cycle returns the old data.
- Program inputs are ignored in run mode. CPU inputs are ignored in program mode.
- FSM states: IDLE, LOAD, CLEAR, DONE.
- IDLE (program mode):
  - clear_req -> CLEAR, ptr=0.
  - else prog_start -> LOAD, ptr=prog_base, prog_count=0.
  - clear_req wins over a simultaneous prog_start.
- LOAD:
  - prog_ready=1.
  - On prog_valid&prog_ready: mem[ptr] <= prog_data, ptr++ (wraps DEPTH-1 -> 0), prog_count++.
  - prog_last accepted, or prog_count reaching DEPTH -> DONE. Writes stop at DEPTH; the array is never overwritten twice in one load.
  - prog_start/clear_req are ignored while in LOAD.
- CLEAR: one word per cycle, mem[ptr] <= CLEAR_VALUE. After writing DEPTH-1 -> DONE (DEPTH cycles total). prog_ready=0.
- DONE: prog_done=1 for one cycle, then IDLE. prog_count holds until the next prog_start.
- busy=1 exactly in LOAD and CLEAR.
- run_not_prog rising while in LOAD/CLEAR: abort to IDLE next cycle.
  - No prog_done pulse.
  - Already written words remain.
  - prog_count keeps the partial value.
- rst mid-operation: immediate IDLE with all outputs at reset values. The array keeps whatever was already written.

Optional Feature:
- Macro: SRAM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on every write (CPU, load, clear).
  - On a run-mode read, parity_err is registered alongside rd_data and is 1 for that cycle if the stored parity mismatches.
  - Test hook: input-free; the bench corrupts the array via hierarchical force.
- Undefined: no parity storage; parity_err is tied to 0.

Decomposition:
- Package sap1_sram_pkg:
  - state enum type (IDLE, LOAD, CLEAR, DONE);
  - function for even parity.
- DEPTH stays a module localparam derived from ADDR_WIDTH.
- One sub-module: sap1_sram_array, a plain clocked storage array with one write port and one registered read port, width DATA_WIDTH (+1 with parity). The top owns muxing and the FSM.

Test Plan:
- Reset then run mode, write 0xA5 @3 (ce_bar=0, we_bar=0), read @3 -> rd_data=0xA5 one cycle later, rd_valid pulse.
- Program mode, prog_start with base=14, stream 0x11,0x22,0x33 with prog_last on 0x33 -> mem[14]=0x11, mem[15]=0x22, mem[0]=0x33 (wrap), prog_count=3, single prog_done pulse.
- Load with prog_valid toggling every other cycle and no prog_last -> accepts exactly 16 words, then DONE, prog_count=16, 17th word not accepted (prog_ready=0).
- clear_req and prog_start in the same cycle -> CLEAR taken, busy high 16 cycles, all words 0x00, prog_done after the last write.
- run_not_prog raised after 2 load words -> IDLE, no prog_done, prog_count=2, CPU reads see the 2 words written.
- With SRAM_PARITY_EN defined: force flip of bit 0 of mem[5] -> run read @5 gives parity_err=1 with rd_data. Unflipped read -> 0.
